// File: rtl/audio_mixer_n.sv
// audio_mixer_n: N-channel stereo mixer with per-channel 4-bit gains and
// 1-bit sigma-delta outputs. One multiply-accumulate per side per clock;
// a frame takes NCH accumulate cycles plus one load cycle.
//
// Ports:
//   clk, rst_n            mixer clock, asynchronous active-low reset
//   ce                    sample strobe; starts a frame when idle
//   ch_left, ch_right     packed samples, channel i at [i*W +: W]
//   vol_we/vol_sel/vol_din  gain register write, vol_din = {gain_l, gain_r}
//   mute                  zeroes both levels at the next frame load
//   busy, overrun         frame in progress / ce dropped while busy (1 clk)
//   level_left/right      current mixed levels
//   audio_left/right      sigma-delta bitstreams
module audio_mixer_n #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned VOLW = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    ce,
   input  logic [NCH*W-1:0]                        ch_left,
   input  logic [NCH*W-1:0]                        ch_right,
   input  logic                                    vol_we,
   input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]  vol_sel,
   input  logic [2*VOLW-1:0]                       vol_din,
   input  logic                                    mute,
   output logic                                    busy,
   output logic                                    overrun,
   output logic [W-1:0]                            level_left,
   output logic [W-1:0]                            level_right,
   output logic                                    audio_left,
   output logic                                    audio_right
);

   localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned SH   = $clog2(NCH);
   localparam int unsigned AW   = W + VOLW + SH;

   typedef enum logic [1:0] {StIdle, StAcc, StLoad} state_e;

   state_e             state_q, state_d;
   logic [SELW-1:0]    idx_q, idx_d;
   logic [VOLW-1:0]    gain_l_q [NCH], gain_l_d [NCH];
   logic [VOLW-1:0]    gain_r_q [NCH], gain_r_d [NCH];
   logic [VOLW-1:0]    fgain_l_q [NCH], fgain_l_d [NCH];
   logic [VOLW-1:0]    fgain_r_q [NCH], fgain_r_d [NCH];
   logic [W-1:0]       smp_l_q [NCH], smp_l_d [NCH];
   logic [W-1:0]       smp_r_q [NCH], smp_r_d [NCH];
   logic [AW-1:0]      acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [W-1:0]       level_l_q, level_l_d, level_r_q, level_r_d;
   logic [W:0]         sd_l_q, sd_l_d, sd_r_q, sd_r_d;
   logic               overrun_q, overrun_d;
   logic [W+VOLW-1:0]  prod_l, prod_r;

   // Operands zero-extended so the product is computed at full width.
   assign prod_l = {{VOLW{1'b0}}, smp_l_q[idx_q]} * {{W{1'b0}}, fgain_l_q[idx_q]};
   assign prod_r = {{VOLW{1'b0}}, smp_r_q[idx_q]} * {{W{1'b0}}, fgain_r_q[idx_q]};

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gain_l_d  = gain_l_q;
      gain_r_d  = gain_r_q;
      fgain_l_d = fgain_l_q;
      fgain_r_d = fgain_r_q;
      smp_l_d   = smp_l_q;
      smp_r_d   = smp_r_q;
      acc_l_d   = acc_l_q;
      acc_r_d   = acc_r_q;
      level_l_d = level_l_q;
      level_r_d = level_r_q;
      overrun_d = ce && (state_q != StIdle);

      // Gain writes land in the live registers only; frames use the snapshot.
      if (vol_we && (32'(vol_sel) < NCH)) begin
         gain_l_d[vol_sel] = vol_din[2*VOLW-1:VOLW];
         gain_r_d[vol_sel] = vol_din[VOLW-1:0];
      end

      unique case (state_q)
         StIdle: begin
            if (ce) begin
               for (int i = 0; i < NCH; i++) begin
                  smp_l_d[i]   = ch_left[i*W +: W];
                  smp_r_d[i]   = ch_right[i*W +: W];
                  fgain_l_d[i] = gain_l_q[i];
                  fgain_r_d[i] = gain_r_q[i];
               end
               acc_l_d = '0;
               acc_r_d = '0;
               idx_d   = '0;
               state_d = StAcc;
            end
         end
         StAcc: begin
            acc_l_d = acc_l_q + AW'(prod_l);
            acc_r_d = acc_r_q + AW'(prod_r);
            if (idx_q == SELW'(NCH - 1)) begin
               state_d = StLoad;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StLoad: begin
            level_l_d = mute ? '0 : acc_l_q[AW-1 -: W];
            level_r_d = mute ? '0 : acc_r_q[AW-1 -: W];
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // First-order modulator: the carry out of the W-bit phase is the bit.
      sd_l_d = {1'b0, sd_l_q[W-1:0]} + {1'b0, level_l_q};
      sd_r_d = {1'b0, sd_r_q[W-1:0]} + {1'b0, level_r_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         for (int i = 0; i < NCH; i++) begin
            gain_l_q[i]  <= '1;
            gain_r_q[i]  <= '1;
            fgain_l_q[i] <= '0;
            fgain_r_q[i] <= '0;
            smp_l_q[i]   <= '0;
            smp_r_q[i]   <= '0;
         end
         acc_l_q   <= '0;
         acc_r_q   <= '0;
         level_l_q <= '0;
         level_r_q <= '0;
         sd_l_q    <= '0;
         sd_r_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gain_l_q  <= gain_l_d;
         gain_r_q  <= gain_r_d;
         fgain_l_q <= fgain_l_d;
         fgain_r_q <= fgain_r_d;
         smp_l_q   <= smp_l_d;
         smp_r_q   <= smp_r_d;
         acc_l_q   <= acc_l_d;
         acc_r_q   <= acc_r_d;
         level_l_q <= level_l_d;
         level_r_q <= level_r_d;
         sd_l_q    <= sd_l_d;
         sd_r_q    <= sd_r_d;
         overrun_q <= overrun_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign overrun     = overrun_q;
   assign level_left  = level_l_q;
   assign level_right = level_r_q;
   assign audio_left  = sd_l_q[W];
   assign audio_right = sd_r_q[W];

endmodule

// File: tb/tb_audio_mixer_n.sv
// Directed bench for audio_mixer_n (NCH=4, W=8, VOLW=4).
module tb_audio_mixer_n;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic [31:0] ch_left;
   logic [31:0] ch_right;
   logic        vol_we;
   logic [1:0]  vol_sel;
   logic [7:0]  vol_din;
   logic        mute;
   logic        busy;
   logic        overrun;
   logic [7:0]  level_left;
   logic [7:0]  level_right;
   logic        audio_left;
   logic        audio_right;

   int n_checks = 0;
   int n_errors = 0;

   audio_mixer_n #(.NCH(4), .W(8), .VOLW(4)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce          (ce),
      .ch_left     (ch_left),
      .ch_right    (ch_right),
      .vol_we      (vol_we),
      .vol_sel     (vol_sel),
      .vol_din     (vol_din),
      .mute        (mute),
      .busy        (busy),
      .overrun     (overrun),
      .level_left  (level_left),
      .level_right (level_right),
      .audio_left  (audio_left),
      .audio_right (audio_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse ce for one edge; returns after that edge.
   task automatic start_frame();
      ce = 1'b1;
      tick();
      ce = 1'b0;
   endtask

   // Counts samples with busy high, starting at the current sample.
   task automatic wait_idle(output int nb);
      nb = 0;
      for (int k = 0; k < 20; k++) begin
         if (!busy) break;
         nb++;
         tick();
      end
      if (busy) check("idle_timeout", busy, 0);
   endtask

   task automatic count_ones(output int nl, output int nr);
      nl = 0;
      nr = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         nl += int'(audio_left);
         nr += int'(audio_right);
      end
   endtask

   function automatic logic [31:0] all4(input logic [7:0] v);
      return {v, v, v, v};
   endfunction

   int nb, nl, nr;

   initial begin
      rst_n    = 1'b1;
      ce       = 1'b0;
      ch_left  = '0;
      ch_right = '0;
      vol_we   = 1'b0;
      vol_sel  = '0;
      vol_din  = '0;
      mute     = 1'b0;

      // 1. Asynchronous reset mid-clock, before any edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_level_l", level_left, 0);
      check("rst_level_r", level_right, 0);
      check("rst_audio_l", audio_left, 0);
      check("rst_audio_r", audio_right, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset gain readback: 255*15 >> 6 = 59 on both sides.
      ch_left  = 32'h0000_00FF;
      ch_right = 32'h0000_00FF;
      start_frame();
      wait_idle(nb);
      check("gain_rst_l", level_left, 59);
      check("gain_rst_r", level_right, 59);

      // 2. Single channel on the left only.
      ch_right = '0;
      start_frame();
      wait_idle(nb);
      check("single_busy_clks", nb, 5);
      check("single_level_l", level_left, 59);
      check("single_level_r", level_right, 0);
      count_ones(nl, nr);
      check("single_ones_l", nl, 59);
      check("single_ones_r", nr, 0);

      // 3. Full scale: 4*255*15 = 15300 >> 6 = 239.
      ch_left  = all4(8'hFF);
      ch_right = all4(8'hFF);
      start_frame();
      wait_idle(nb);
      check("full_level_l", level_left, 239);
      check("full_level_r", level_right, 239);
      count_ones(nl, nr);
      check("full_ones_l", nl, 239);
      check("full_ones_r", nr, 239);

      // 4. Gain write mid-frame, then next frame, then mute.
      ch_left  = all4(8'h80);
      ch_right = all4(8'h80);
      start_frame();              // edge T
      tick();                     // edge T+1
      vol_we  = 1'b1;
      vol_sel = 2'd2;
      vol_din = 8'h0F;            // gain_left ch2 = 0, gain_right ch2 = 15
      tick();                     // edge T+2
      vol_we  = 1'b0;
      wait_idle(nb);
      check("gainwr_cur_l", level_left, 120);
      check("gainwr_cur_r", level_right, 120);
      start_frame();
      wait_idle(nb);
      check("gainwr_next_l", level_left, 90);
      check("gainwr_next_r", level_right, 120);
      start_frame();
      mute = 1'b1;                // raised mid-frame, held through load
      wait_idle(nb);
      mute = 1'b0;
      check("mute_level_l", level_left, 0);
      check("mute_level_r", level_right, 0);
      count_ones(nl, nr);
      check("mute_ones_l", nl, 0);
      check("mute_ones_r", nr, 0);

      // 5. Overrun: ce at T and T+3, new frame at T+6.
      vol_we  = 1'b1;
      vol_sel = 2'd2;
      vol_din = 8'hFF;
      tick();
      vol_we = 1'b0;
      start_frame();              // edge T
      check("ovr_t0", overrun, 0);
      tick();                     // T+1
      tick();                     // T+2
      ce = 1'b1;
      tick();                     // T+3
      ce = 1'b0;
      check("ovr_pulse", overrun, 1);
      check("ovr_busy", busy, 1);
      tick();                     // T+4
      check("ovr_clear", overrun, 0);
      tick();                     // T+5
      check("ovr_done_busy", busy, 0);
      check("ovr_level_l", level_left, 120);
      check("ovr_level_r", level_right, 120);
      ch_left = all4(8'h40);      // 4*64*15 = 3840 >> 6 = 60
      start_frame();              // T+6
      check("ovr_new_noovr", overrun, 0);
      check("ovr_new_busy", busy, 1);
      wait_idle(nb);
      check("ovr_new_clks", nb, 5);
      check("ovr_new_level_l", level_left, 60);

      // 7. ce and vol_we together: snapshot takes the old gain.
      ch_left = all4(8'h80);
      vol_we  = 1'b1;
      vol_sel = 2'd0;
      vol_din = 8'h0F;
      start_frame();
      vol_we = 1'b0;
      wait_idle(nb);
      check("same_cyc_l", level_left, 120);
      start_frame();
      wait_idle(nb);
      check("same_cyc_next_l", level_left, 90);

      // 6. Reset mid-frame; gains return to all ones.
      start_frame();              // edge T
      tick();                     // T+1
      tick();                     // T+2
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_level_l", level_left, 0);
      check("midrst_level_r", level_right, 0);
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("midrst_idle", busy, 0);
      check("midrst_noload_l", level_left, 0);
      check("midrst_noload_r", level_right, 0);
      start_frame();
      wait_idle(nb);
      check("midrst_gain_l", level_left, 120);
      check("midrst_gain_r", level_right, 120);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
